// File: rtl/pe_mac_bank.sv
// Bank of signed fixed-point multiply-accumulators with a read-and-clear port.
// Each result is rounded half toward +inf and saturated, then held in a valid/ready output register.
module pe_mac_bank #(
    parameter int INT_BITS   = 7,
    parameter int FRAC_BITS  = 9,
    parameter int NUM_ACC    = 8,
    parameter int GUARD_BITS = 4,
    localparam int W  = INT_BITS + FRAC_BITS,
    localparam int SW = $clog2(NUM_ACC),
    localparam int AW = 2 * W + GUARD_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_a,
    input  logic signed [W-1:0] in_b,
    input  logic [SW-1:0]       acc_sel,
    input  logic                rd_req,
    input  logic [SW-1:0]       rd_sel,
    output logic                rd_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_sat
);

    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] HALF    = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W-1:0] w_prod;
    logic                  w_beat;
    logic                  w_rd_accept;

    logic                  r_s1_valid;
    logic signed [2*W-1:0] r_s1_prod;
    logic [SW-1:0]         r_s1_sel;

    logic signed [AW-1:0]  r_acc [NUM_ACC];
    logic signed [AW-1:0]  w_acc_next [NUM_ACC];

    logic                  r_rd_v1;
    logic                  r_rd_v2;
    logic [SW-1:0]         r_rd_sel1;
    logic [SW-1:0]         r_rd_sel2;

    logic signed [AW-1:0]  w_rd_val;
    logic signed [RW-1:0]  w_rnd_sum;
    logic signed [RW-1:0]  w_rnd_shift;
    logic [W-1:0]          w_res_data;
    logic                  w_res_sat;

    logic                  r_out_valid;
    logic [W-1:0]          r_out_data;
    logic                  r_out_sat;

    assign w_prod      = in_a * in_b;
    assign w_beat      = in_valid && !stall;
    assign rd_ready    = !r_rd_v1 && !r_rd_v2 && !(r_out_valid && !out_ready) && !stall;
    assign w_rd_accept = rd_req && rd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_sel   <= '0;
        end else if (!stall) begin
            r_s1_valid <= w_beat;
            r_s1_prod  <= w_prod;
            r_s1_sel   <= acc_sel;
        end
    end

    // Clear from a completing read is applied before the stage-2 add, so a same-index add survives.
    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            w_acc_next[i] = r_acc[i];
            if (r_rd_v2 && r_rd_sel2 == SW'(i)) begin
                w_acc_next[i] = '0;
            end
            if (r_s1_valid && r_s1_sel == SW'(i)) begin
                w_acc_next[i] = w_acc_next[i] + {{GUARD_BITS{r_s1_prod[2*W-1]}}, r_s1_prod};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= w_acc_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_v1   <= 1'b0;
            r_rd_v2   <= 1'b0;
            r_rd_sel1 <= '0;
            r_rd_sel2 <= '0;
        end else if (!stall) begin
            r_rd_v1   <= w_rd_accept;
            r_rd_v2   <= r_rd_v1;
            r_rd_sel1 <= rd_sel;
            r_rd_sel2 <= r_rd_sel1;
        end
    end

    // One extra bit keeps the rounding increment from wrapping at the top of the range.
    always_comb begin
        w_rd_val    = r_acc[r_rd_sel2];
        w_rnd_sum   = {w_rd_val[AW-1], w_rd_val} + HALF;
        w_rnd_shift = w_rnd_sum >>> FRAC_BITS;
        w_res_data  = w_rnd_shift[W-1:0];
        w_res_sat   = 1'b0;
        if (w_rnd_shift > SAT_MAX) begin
            w_res_data = {1'b0, {(W-1){1'b1}}};
            w_res_sat  = 1'b1;
        end else if (w_rnd_shift < SAT_MIN) begin
            w_res_data = {1'b1, {(W-1){1'b0}}};
            w_res_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (r_rd_v2 && !stall) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res_data;
            r_out_sat   <= w_res_sat;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
